// File: rtl/horner_pkg.sv
// Shared types for the Horner-form quadratic evaluator: FSM states and ALU controls.
package horner_pkg;

    typedef enum logic [3:0] {
        S_LOAD_A,
        S_LOAD_A_WAIT,
        S_LOAD_B,
        S_LOAD_B_WAIT,
        S_LOAD_C,
        S_LOAD_C_WAIT,
        S_LOAD_X,
        S_LOAD_X_WAIT,
        S_CYCLE_0,
        S_CYCLE_1,
        S_CYCLE_2,
        S_CYCLE_3
    } state_t;

    typedef enum logic {ADD, MUL} alu_op_t;

    typedef enum logic [2:0] {SEL_A, SEL_B, SEL_C, SEL_X, SEL_ACC} alu_sel_t;

endpackage

// File: rtl/horner_datapath.sv
// Operand registers, accumulator and result register around one shared add/multiply ALU.
module horner_datapath
    import horner_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             ld_c,
    input  logic             ld_x,
    input  logic             ld_acc,
    input  logic             ld_r,
    input  alu_sel_t         sel_a,
    input  alu_sel_t         sel_b,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d, r_q, r_d;
    logic [WIDTH-1:0] opnd_a, opnd_b, alu_y;

    // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        opnd_a = acc_q;
        opnd_b = acc_q;
        case (sel_a)
            SEL_A:   opnd_a = a_q;
            SEL_B:   opnd_a = b_q;
            SEL_C:   opnd_a = c_q;
            SEL_X:   opnd_a = x_q;
            default: opnd_a = acc_q;
        endcase
        case (sel_b)
            SEL_A:   opnd_b = a_q;
            SEL_B:   opnd_b = b_q;
            SEL_C:   opnd_b = c_q;
            SEL_X:   opnd_b = x_q;
            default: opnd_b = acc_q;
        endcase

        // Truncation to WIDTH bits gives the mod 2^WIDTH arithmetic directly.
        alu_y = (op == MUL) ? opnd_a * opnd_b : opnd_a + opnd_b;

        a_d   = ld_a   ? data_in : a_q;
        b_d   = ld_b   ? data_in : b_q;
        c_d   = ld_c   ? data_in : c_q;
        x_d   = ld_x   ? data_in : x_q;
        acc_d = ld_acc ? alu_y   : acc_q;
        r_d   = ld_r   ? alu_y   : r_q;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            x_q   <= '0;
            acc_q <= '0;
            r_q   <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            x_q   <= x_d;
            acc_q <= acc_d;
            r_q   <= r_d;
        end
    end

    assign result = r_q;

endmodule

// File: rtl/horner_sequencer.sv
// Go-handshake operand loader plus a four-cycle compute schedule evaluating (A*x + B)*x + C.
module horner_sequencer
    import horner_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Go,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataResult,
    output logic             ResultValid,
    output logic             Busy,
    output logic [1:0]       OperandSel
);

    state_t   state_q, state_d;
    logic     valid_q, valid_d;
    logic     ld_a, ld_b, ld_c, ld_x, ld_acc, ld_r;
    alu_sel_t sel_a, sel_b;
    alu_op_t  op;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_c       = 1'b0;
        ld_x       = 1'b0;
        ld_acc     = 1'b0;
        ld_r       = 1'b0;
        sel_a      = SEL_ACC;
        sel_b      = SEL_X;
        op         = ADD;
        Busy       = 1'b0;
        OperandSel = 2'd0;
        case (state_q)
            S_LOAD_A: if (Go) begin
                ld_a    = 1'b1;
                valid_d = 1'b0;
                state_d = S_LOAD_A_WAIT;
            end
            S_LOAD_A_WAIT: if (!Go) state_d = S_LOAD_B;
            S_LOAD_B: begin
                OperandSel = 2'd1;
                if (Go) begin
                    ld_b    = 1'b1;
                    state_d = S_LOAD_B_WAIT;
                end
            end
            S_LOAD_B_WAIT: begin
                OperandSel = 2'd1;
                if (!Go) state_d = S_LOAD_C;
            end
            S_LOAD_C: begin
                OperandSel = 2'd2;
                if (Go) begin
                    ld_c    = 1'b1;
                    state_d = S_LOAD_C_WAIT;
                end
            end
            S_LOAD_C_WAIT: begin
                OperandSel = 2'd2;
                if (!Go) state_d = S_LOAD_X;
            end
            S_LOAD_X: begin
                OperandSel = 2'd3;
                if (Go) begin
                    ld_x    = 1'b1;
                    state_d = S_LOAD_X_WAIT;
                end
            end
            S_LOAD_X_WAIT: begin
                OperandSel = 2'd3;
                if (!Go) state_d = S_CYCLE_0;
            end
            // Compute states ignore Go entirely.
            S_CYCLE_0: begin
                Busy    = 1'b1;
                ld_acc  = 1'b1;
                sel_a   = SEL_A;
                sel_b   = SEL_X;
                op      = MUL;
                state_d = S_CYCLE_1;
            end
            S_CYCLE_1: begin
                Busy    = 1'b1;
                ld_acc  = 1'b1;
                sel_b   = SEL_B;
                state_d = S_CYCLE_2;
            end
            S_CYCLE_2: begin
                Busy    = 1'b1;
                ld_acc  = 1'b1;
                op      = MUL;
                state_d = S_CYCLE_3;
            end
            S_CYCLE_3: begin
                Busy    = 1'b1;
                ld_r    = 1'b1;
                sel_b   = SEL_C;
                valid_d = 1'b1;
                state_d = S_LOAD_A;
            end
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_LOAD_A;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    assign ResultValid = valid_q;

    horner_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (Clock),
        .rst_n   (Resetn),
        .ld_a    (ld_a),
        .ld_b    (ld_b),
        .ld_c    (ld_c),
        .ld_x    (ld_x),
        .ld_acc  (ld_acc),
        .ld_r    (ld_r),
        .sel_a   (sel_a),
        .sel_b   (sel_b),
        .op      (op),
        .data_in (DataIn),
        .result  (DataResult)
    );

endmodule

// File: tb/tb_horner_sequencer.sv
// Scoreboard bench for horner_sequencer: expected results come from polynomial arithmetic.
module tb_horner_sequencer;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         go    = 1'b0;
    logic [W-1:0] din   = '0;
    logic [W-1:0] dout;
    logic         valid;
    logic         busy;
    logic [1:0]   opsel;

    horner_sequencer #(.WIDTH(W)) dut (
        .Clock       (clk),
        .Resetn      (rst_n),
        .Go          (go),
        .DataIn      (din),
        .DataResult  (dout),
        .ResultValid (valid),
        .Busy        (busy),
        .OperandSel  (opsel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] y;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input int a, input int b, input int c, input int x);
        int y;
        y = a * x * x + b * x + c;
        return W'(y % (1 << W));
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One Go press for operand k; the X press also schedules the expected result.
    task automatic press(input int k, input logic [W-1:0] v, input int hold, input int rel,
                         input logic [W-1:0] y_exp, input bit toggle);
        check($sformatf("opsel_idle_%0d", k), opsel, k);
        go  = 1'b1;
        din = v;
        for (int i = 0; i < hold; i++) begin
            tick(1);
            din = W'($urandom);
            check($sformatf("opsel_held_%0d", k), opsel, k);
        end
        go = 1'b0;
        if (k == 3) sb_q.push_back('{y: y_exp, due: cyc + 5});
        if (k == 3 && toggle) begin
            tick(1); go = 1'b1; din = W'($urandom);
            tick(1); go = 1'b0; din = W'($urandom);
            tick(1); go = 1'b1; din = W'($urandom);
            tick(1); go = 1'b1; din = W'($urandom);
            tick(1); go = 1'b0;
        end
        tick(rel);
    endtask

    task automatic run_seq(input int a, input int b, input int c, input int x,
                           input int hold, input int rel, input bit toggle);
        press(0, W'(a), hold, rel, '0, 1'b0);
        press(1, W'(b), hold, rel, '0, 1'b0);
        press(2, W'(c), hold, rel, '0, 1'b0);
        press(3, W'(x), hold, 6, model(a, b, c, x), toggle);
    endtask

    // Monitor: pops the scoreboard on each new result and checks compute length.
    bit prev_v   = 1'b0;
    int busy_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v   = 1'b0;
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                check("busy_len", busy_run, 4);
                busy_run = 0;
            end
            if (valid && !prev_v) begin
                if (sb_q.size() == 0) check("unexpected_result", valid, 0);
                else begin
                    e = sb_q.pop_front();
                    check("result", dout, e.y);
                    check("latency", cyc, e.due);
                end
            end
            prev_v = valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(2);
        check("rst_result", dout, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_opsel", opsel, 0);
        rst_n = 1'b1;
        tick(2);

        // Basic 2,3,4,5 -> 69
        run_seq(2, 3, 4, 5, 3, 2, 1'b0);
        tick(3);
        check("valid_held_idle", valid, 1);
        check("result_69", dout, 8'h45);

        // New A capture drops ResultValid but keeps the old result
        go = 1'b1; din = 8'd7;
        tick(1);
        check("valid_drop_on_a", valid, 0);
        check("result_kept_a", dout, 8'h45);
        go = 1'b0;
        tick(2);
        press(1, 8'd9, 1, 1, '0, 1'b0);
        check("result_kept_b", dout, 8'h45);
        press(2, 8'd11, 2, 1, '0, 1'b0);
        check("result_kept_c", dout, 8'h45);
        press(3, 8'd13, 1, 6, model(7, 9, 11, 13), 1'b0);

        // Go toggled during compute has no effect
        run_seq(2, 3, 4, 5, 2, 2, 1'b1);
        check("result_toggle", dout, 8'h45);

        // Asynchronous reset in S_CYCLE_2
        press(0, 8'd20, 1, 1, '0, 1'b0);
        press(1, 8'd21, 1, 1, '0, 1'b0);
        press(2, 8'd22, 1, 1, '0, 1'b0);
        go = 1'b1; din = 8'd23;
        tick(1);
        go = 1'b0;
        tick(3);
        check("busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", dout, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_opsel", opsel, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        run_seq(1, 1, 1, 1, 1, 1, 1'b0);

        // Wraparound cases
        run_seq(8'h10, 0, 1, 8'h10, 2, 1, 1'b0);
        run_seq(8'hFF, 1, 0, 1, 1, 2, 1'b0);

        // Long Go hold on A loads only A
        press(0, 8'd6, 20, 2, '0, 1'b0);
        press(1, 8'd5, 1, 1, '0, 1'b0);
        press(2, 8'd4, 1, 1, '0, 1'b0);
        press(3, 8'd3, 2, 6, model(6, 5, 4, 3), 1'b0);

        // Randomised sequences
        for (int n = 0; n < 30; n++)
            run_seq(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), n[0]);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick(1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/horner_sequencer.md
Name: horner_sequencer

Overview:
- Sequenced evaluator for y = A*x^2 + B*x + C mod 2^WIDTH, computed in Horner form y = (A*x + B)*x + C.
- An operand-load FSM takes four values (A, B, C, X) from a shared DataIn bus, one per Go press/release.
- A compute FSM then time-shares a single add/multiply ALU over four cycles.
- It sits beside the two-operand ALU datapath as the next lab step: the same Go handshake, with more operands and more ALU scheduling.

Parameters:
- WIDTH, 8, data width of DataIn, operand registers, accumulator and DataResult.

Ports:
- Clock  input  1  system clock, rising-edge.
- Resetn  input  1  asynchronous, active-low reset.
- Go  input  1  operand-load strobe (synchronous, level).
- DataIn  input  WIDTH  operand value; captured per the load rules below.
- DataResult  output  WIDTH  last completed y; changes only at compute end.
- ResultValid  output  1  DataResult holds a result not yet superseded by a new load sequence.
- Busy  output  1  high during the compute states.
- OperandSel  output  2  operand expected next: 0=A, 1=B, 2=C, 3=X; 0 outside load states.

Behaviour:
Reset:
- One clock; reset is asynchronous and active-low (Resetn), clock is Clock.
- Resetn=0 forces state S_LOAD_A and clears A, B, C, X, ACC, DataResult and ResultValid to 0.
- Busy=0 and OperandSel=0 during reset.
- Reset mid-compute aborts the computation. DataResult keeps its reset value of 0; it does not keep any partial value.

States, in order: S_LOAD_A, S_LOAD_A_WAIT, S_LOAD_B, S_LOAD_B_WAIT, S_LOAD_C, S_LOAD_C_WAIT, S_LOAD_X, S_LOAD_X_WAIT, S_CYCLE_0, S_CYCLE_1, S_CYCLE_2, S_CYCLE_3.

Load rules:
- In S_LOAD_k with Go=1: capture DataIn into register k on that edge and move to S_LOAD_k_WAIT. With Go=0, stay.
- In S_LOAD_k_WAIT: stay while Go=1. With Go=0, advance to the next S_LOAD state; after X, advance to S_CYCLE_0.
- Each press loads exactly one operand, however long Go is held.

Compute schedule (one ALU, ops are add/mul, operand muxes select from A, B, C, X, ACC):
- S_CYCLE_0: ACC <= A*X
- S_CYCLE_1: ACC <= ACC+B
- S_CYCLE_2: ACC <= ACC*X
- S_CYCLE_3: DataResult <= ACC+C, ResultValid <= 1, next state S_LOAD_A
- The ALU result is the low WIDTH bits of the sum or product; carries and high product bits are discarded.

Latency:
- Take the edge that samples Go=0 in S_LOAD_X_WAIT.
- DataResult and ResultValid update exactly 4 edges later, on the edge leaving S_CYCLE_3.

Outputs:
- Busy=1 exactly in S_CYCLE_0..3.
- OperandSel is driven from the current state, combinationally.
- ResultValid stays 1 in S_LOAD_A.
- ResultValid clears on the edge that captures a new A. DataResult still holds the old value until the next S_CYCLE_3.

Boundaries:
- Go is ignored in all S_CYCLE states.
- If Go=1 on entry to S_LOAD_A, A is captured on the first S_LOAD_A edge.
- DataIn is don't-care except on capture edges.
- The unused state encoding recovers to S_LOAD_A.
- A, B, C and X hold their values between sequences. Only a capture edge overwrites them.

Decomposition:
Package horner_pkg holds:
- the state enum;
- alu_op_t (ADD, MUL);
- alu_sel_t (SEL_A, SEL_B, SEL_C, SEL_X, SEL_ACC).

One sub-module, horner_datapath, contains:
- the operand registers, ACC and DataResult;
- two alu_sel_t muxes and the ALU.

Its inputs are load enables per register, ld_acc, ld_r, sel_a, sel_b and op from the FSM in horner_sequencer.

Test Plan:
1. Load A=2, B=3, C=4, X=5 (Go held 3 cycles each, released 2 cycles) -> after 4 edges DataResult=0x45 (69), ResultValid=1, Busy high for exactly 4 cycles.
2. Wrap: A=0x10, B=0, C=1, X=0x10 -> DataResult=0x01. Also A=0xFF, B=1, C=0, X=1 -> DataResult=0x00.
3. Go held 20 cycles on A -> only A loaded, OperandSel stays 0 then 1 after release. Next press loads B, not A again.
4. Assert Resetn=0 asynchronously (between edges) in S_CYCLE_2 -> DataResult=0, ResultValid=0 and state S_LOAD_A immediately, not at the next edge. A fresh sequence 1,1,1,1 then yields 3.
5. After result 69, press Go with DataIn=7 -> ResultValid drops on that edge, DataResult stays 0x45 until the new compute finishes.
6. Go toggled during S_CYCLE_0..3 -> no register or state change beyond the schedule; the result matches scenario 1.
